// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2 convolutional encoder with valid/ready framing and K-1 zero tail bits per frame.
module conv_encoder #(
  parameter int             K     = 3,
  parameter logic [K-1:0]   G0    = 3'b111,
  parameter logic [K-1:0]   G1    = 3'b101,
  parameter int             CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_sym,
  output logic             out_last,
  output logic [CNT_W-1:0] sym_cnt,
  output logic             busy
);
  localparam int TW = $clog2(K);
  typedef enum logic [1:0] {IDLE, ENCODE, FLUSH} state_t;
  state_t           state_q, state_d;
  logic [K-2:0]     sr_q, sr_d;
  logic [TW-1:0]    tail_cnt_q, tail_cnt_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             adv, step;
  logic [K-1:0]     w;
  always_comb begin
    adv         = !out_valid_q || out_ready;
    in_ready    = adv && (state_q != FLUSH);
    step        = (in_valid && in_ready) || (adv && state_q == FLUSH);
    w           = {(state_q == FLUSH) ? 1'b0 : in_bit, sr_q};
    state_d     = state_q;
    sr_d        = sr_q;
    tail_cnt_d  = tail_cnt_q;
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    sym_cnt_d   = sym_cnt_q;
    if (step) begin
      sr_d        = w[K-1:1];
      out_sym_d   = {^(w & G0), ^(w & G1)};
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      sym_cnt_d   = (state_q == IDLE) ? CNT_W'(1) : sym_cnt_q + CNT_W'(1);
      if (state_q == FLUSH) begin
        tail_cnt_d = tail_cnt_q + TW'(1);
        if (tail_cnt_q == TW'(K - 2)) begin
          out_last_d = 1'b1;
          state_d    = IDLE;
        end
      end else begin
        state_d    = in_last ? FLUSH : ENCODE;
        tail_cnt_d = '0;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      tail_cnt_q  <= '0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tail_cnt_q  <= tail_cnt_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end
  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign sym_cnt   = sym_cnt_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder: directed and random frames through K=3 and K=7 encoders, checked against a convolution model.
module tb_conv_encoder;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [1:0] in_valid = 0, in_bit = 0, in_last = 0, out_ready = 0;
  logic [1:0] in_ready, out_valid, out_last, busy;
  logic [1:0] out_sym [2];
  logic [15:0] sym_cnt [2];
  int kk [2] = '{3, 7};
  int g0 [2] = '{7, 'o171};
  int g1 [2] = '{5, 'o133};
  int tests = 0, fails = 0;
  bit frame_q [$];
  logic [1:0] got_q [$];
  conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bit(in_bit[0]),
    .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sym(out_sym[0]),
    .out_last(out_last[0]), .sym_cnt(sym_cnt[0]), .busy(busy[0]));
  conv_encoder #(.K(7), .G0(7'o171), .G1(7'o133), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bit(in_bit[1]),
    .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sym(out_sym[1]),
    .out_last(out_last[1]), .sym_cnt(sym_cnt[1]), .busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol i is the generator-weighted parity of frame bits i..i-K+1, zero outside the frame.
  function automatic logic [1:0] ref_sym(input int s, input int i);
    logic p1 = 0, p0 = 0, x;
    int t;
    for (int j = 0; j < kk[s]; j++) begin
      t  = i - j;
      x  = (t >= 0 && t < frame_q.size()) ? frame_q[t] : 1'b0;
      p1 ^= g0[s][kk[s]-1-j] & x;
      p0 ^= g1[s][kk[s]-1-j] & x;
    end
    return {p1, p0};
  endfunction

  task automatic run(input int s, input int stall, input int gap, input bit hold);
    int l = frame_q.size();
    int n_exp = l + kk[s] - 1;
    int idx = 0, n = 0, cyc = 0;
    bit done = 0, pstall = 0;
    logic [1:0] ps = 0;
    logic pl = 0;
    got_q.delete();
    while (!done && cyc < 4000) begin
      if (idx < l) begin
        in_valid[s] = $urandom_range(99) >= gap;
        in_bit[s]   = frame_q[idx];
        in_last[s]  = idx == l - 1;
      end else begin
        in_valid[s] = hold;
        in_bit[s]   = 1;
        in_last[s]  = 0;
      end
      out_ready[s] = $urandom_range(99) >= stall;
      #1;
      if (idx >= l && !busy[s]) in_valid[s] = 0;
      if (idx >= l && in_valid[s]) chk("flush_in_ready", in_ready[s], 0);
      if (pstall) begin
        chk("stall_sym", out_sym[s], ps);
        chk("stall_last", out_last[s], pl);
        chk("stall_valid", out_valid[s], 1);
      end
      if (out_valid[s] && !out_ready[s]) chk("stall_in_ready", in_ready[s], 0);
      if (out_valid[s] && out_ready[s]) begin
        chk("sym", out_sym[s], (n < n_exp) ? ref_sym(s, n) : 2'bxx);
        chk("last", out_last[s], n == n_exp - 1);
        chk("sym_cnt", sym_cnt[s], n + 1);
        got_q.push_back(out_sym[s]);
        n++;
        done = n >= n_exp || out_last[s];
      end
      pstall = out_valid[s] && !out_ready[s];
      ps = out_sym[s];
      pl = out_last[s];
      if (in_valid[s] && in_ready[s]) idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid[s] = 0;
    #1;
    chk("frame_done", done, 1);
    chk("accepted", idx, l);
    chk("busy_after", busy[s], 0);
    chk("final_cnt", sym_cnt[s], n_exp);
  endtask

  task automatic load(input int len, input int pat);
    frame_q.delete();
    for (int i = 0; i < len; i++) frame_q.push_back(pat < 0 ? 1'($urandom) : 1'(pat >> (len - 1 - i)));
  endtask

  task automatic chk_seq(input string tag, input logic [1:0] e [5], input int len);
    chk({tag, "_len"}, got_q.size(), len);
    for (int i = 0; i < len && i < got_q.size(); i++) chk(tag, got_q[i], e[i]);
  endtask

  initial begin
    logic [1:0] e1 [5] = '{3, 2, 0, 2, 3};
    logic [1:0] e3 [5] = '{3, 2, 3, 0, 0};
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", out_valid[s], 0);
      chk("rst_sym", out_sym[s], 0);
      chk("rst_last", out_last[s], 0);
      chk("rst_cnt", sym_cnt[s], 0);
      chk("rst_busy", busy[s], 0);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load(3, 3'b101);
    run(0, 0, 0, 0);
    chk_seq("t1", e1, 5);
    load(8, 0);
    run(0, 0, 0, 0);
    for (int i = 0; i < got_q.size(); i++) chk("t2_zero", got_q[i], 0);
    load(1, 1);
    run(0, 0, 0, 0);
    chk_seq("t3", e3, 3);
    load(3, 3'b101);
    run(0, 50, 30, 0);
    chk_seq("t4", e1, 5);
    load(5, -1);
    run(0, 30, 0, 1);
    load(4, -1);
    run(0, 0, 0, 0);
    in_valid[0] = 1; in_bit[0] = 1; in_last[0] = 0; out_ready[0] = 1;
    @(posedge clk);
    @(negedge clk);
    in_bit[0] = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 0;
    #1;
    chk("t6_busy_pre", busy[0], 1);
    rst_n = 0;
    #1;
    chk("t6_valid", out_valid[0], 0);
    chk("t6_sym", out_sym[0], 0);
    chk("t6_last", out_last[0], 0);
    chk("t6_cnt", sym_cnt[0], 0);
    chk("t6_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    load(1, 1);
    run(0, 0, 0, 0);
    chk("t6_first", got_q.size() > 0 ? got_q[0] : 2'bxx, 3);
    for (int s = 0; s < 2; s++)
      for (int f = 0; f < 20; f++) begin
        load($urandom_range(64, 1), -1);
        run(s, $urandom_range(60), $urandom_range(40), 1'($urandom));
      end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
